sparc_exu_ecl_shftctl: RTL and testbench
========================================

// Module: sparc_exu_ecl_shftctl
// PURPOSE
//  Control-side counterpart of the EXU 64-bit barrel shifter. Captures shift
//  ops from the IFU in D, pipelines them D->E->W with stall/kill, and drives
//  every shifter control input in E: enable, direction, op32, one-hot
//  shift4/shift1 selects, and the SRA/32-bit extend bits.
//  Sits in the ECL next to the shifter; outputs feed the shifter directly.
// PARAMETERS
//  none (all widths fixed by the SPARC V9 shift definition)
// PORTS
//  rclk                      in   1   core clock; only clock
//  rst_l                     in   1   synchronous reset, active low
//  ifu_exu_shift_d           in   1   D-stage instruction is a shift
//  ifu_exu_shiftop_d         in   2   00=SLL 01=SRL 10=SRA 11=reserved
//  ifu_exu_op32_d            in   1   32-bit variant (SLL/SRL/SRA, not *X)
//  ifu_exu_flush_d           in   1   D-stage op is squashed; do not capture
//  ecl_stall_e               in   1   hold E-stage register
//  ifu_exu_kill_e            in   1   kill E-stage op (trap/mispredict)
//  byp_alu_rs1_data_e        in   64  E-stage rs1 operand (sign source)
//  byp_alu_rs2_data_e        in   4   E-stage shift count [3:0]
//  ecl_shft_enshift_e_l      out  1   0 = shifter input enabled
//  ecl_shft_lshift_e_l       out  1   0 = left shift, 1 = right shift
//  ecl_shft_op32_e           out  1   32-bit op (upper-half handling)
//  ecl_shft_shift4_e         out  4   one-hot [12,8,4,0] select
//  ecl_shft_shift1_e         out  4   one-hot [3,2,1,0] select
//  ecl_shft_extendbit_e      out  1   fill bit for right shifts
//  ecl_shft_extend32bit_e_l  out  1   0 = fill upper 32 with ones (SRA32)
//  shft_valid_w              out  1   shift result is valid in W
// BEHAVIOUR
//  Reset: rst_l=0 clears valid_e, op_e, op32_e, valid_w at the next rclk edge,
//   regardless of stall/kill. Outputs after reset: enshift_e_l=1,
//   lshift_e_l=1, op32_e=0, extendbit_e=0, extend32bit_e_l=1, valid_w=0;
//   shift4_e/shift1_e follow rs2 decode (always one-hot).
//  D->E capture (edge, ~ecl_stall_e): valid_e <= shift_d & ~flush_d &
//   (shiftop_d!=2'b11); op_e <= shiftop_d; op32_e <= op32_d. Reserved op
//   never becomes valid.
//  Stall: E register holds all fields. Kill has priority over stall:
//   kill_e=1 clears valid_e at the edge even while stalled.
//  E outputs (combinational from E register and E operands, 0-cycle):
//   enshift_e_l = ~valid_e; lshift_e_l = ~(valid_e & op_e==SLL);
//   op32_e_out = valid_e & op32_e;
//   shift4_e[k] = (rs2[3:2]==k); shift1_e[k] = (rs2[1:0]==k); exactly one-hot
//   for every input (shifter muxes require it, incl. idle cycles);
//   sra = valid_e & op_e==SRA; sgn = op32_e ? rs1[31] : rs1[63];
//   extendbit_e = sra & sgn; extend32bit_e_l = ~(sra & op32_e & rs1[31]).
//   Count bits [5:4] go to the shifter from bypass; not handled here.
//  E->W (edge): valid_w <= valid_e & ~kill_e & ~ecl_stall_e (stall = bubble).
//  Latency: D capture -> E controls 1 cycle; E -> valid_w 1 cycle.
//  Back-to-back shifts: one per cycle, no dead cycle.
// STRUCTURE
//  Shared exu package: shift-op encodings (SLL/SRL/SRA/RSVD), 4-way one-hot
//   select width constant.
//  One sub-module: sparc_exu_ecl_dec2to4 (2-bit -> one-hot 4), instanced
//   twice, for shift4 and shift1. Flops via codebase dff primitives.
// TESTING
//  SLL op32=0, rs2=4'hD -> lshift_e_l=0, shift4=4'b1000, shift1=4'b0010,
//   enshift_e_l=0; valid_w=1 next cycle.
//  SRA op32=0, rs1[63]=1, rs2=4'h5 -> extendbit_e=1, extend32bit_e_l=1,
//   shift4=4'b0010, shift1=4'b0010.
//  SRA op32=1, rs1=64'h0000_0000_8000_0000 -> extendbit_e=1,
//   extend32bit_e_l=0; SRL op32=1 same rs1 -> both fills 0/1 (inactive).
//  Stall E 3 cycles with kill_e in cycle 2 -> valid_e cleared at kill,
//   enshift_e_l=1 after, valid_w stays 0 throughout.
//  shiftop_d=2'b11 or flush_d=1 -> valid_e=0, enshift_e_l=1, valid_w=0.
//  rst_l=0 mid-stall with valid_e=1 -> all outputs at reset values next
//   edge; shift4/shift1 remain one-hot (bench asserts one-hot every cycle).

Source files
------------

// File: rtl/sparc_exu_ecl_shftctl_pkg.sv
// Shared EXU shift-control definitions: shift-op encodings and select width.
package sparc_exu_ecl_shftctl_pkg;

  typedef enum logic [1:0] {
    SHOP_SLL  = 2'b00,
    SHOP_SRL  = 2'b01,
    SHOP_SRA  = 2'b10,
    SHOP_RSVD = 2'b11
  } shift_op_e;

  // Width of the one-hot shift4/shift1 mux selects.
  localparam int SEL_W = 4;

endpackage

// File: rtl/sparc_exu_ecl_shftctl_dec2to4.sv
// 2-bit to one-hot-4 decoder driving a shifter mux select.
module sparc_exu_ecl_dec2to4
  import sparc_exu_ecl_shftctl_pkg::*;
(
  input  logic [1:0]       sel,
  output logic [SEL_W-1:0] onehot
);

  // Exactly one bit set for every input, so the mux is never left undriven.
  always_comb begin
    onehot      = '0;
    onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/sparc_exu_ecl_shftctl.sv
// Shifter control: captures shift ops in D, holds them in E under
// stall/kill, drives the barrel-shifter controls in E and flags W validity.
module sparc_exu_ecl_shftctl
  import sparc_exu_ecl_shftctl_pkg::*;
(
  input  logic             rclk,
  input  logic             rst_l,
  input  logic             ifu_exu_shift_d,
  input  logic [1:0]       ifu_exu_shiftop_d,
  input  logic             ifu_exu_op32_d,
  input  logic             ifu_exu_flush_d,
  input  logic             ecl_stall_e,
  input  logic             ifu_exu_kill_e,
  input  logic [63:0]      byp_alu_rs1_data_e,
  input  logic [3:0]       byp_alu_rs2_data_e,
  output logic             ecl_shft_enshift_e_l,
  output logic             ecl_shft_lshift_e_l,
  output logic             ecl_shft_op32_e,
  output logic [SEL_W-1:0] ecl_shft_shift4_e,
  output logic [SEL_W-1:0] ecl_shft_shift1_e,
  output logic             ecl_shft_extendbit_e,
  output logic             ecl_shft_extend32bit_e_l,
  output logic             shft_valid_w
);

  logic      valid_e;
  shift_op_e op_e;
  logic      op32_e;
  logic      valid_d;
  logic      sra_e;
  logic      sgn_e;

  // Reserved encoding and flushed ops never enter E as valid.
  assign valid_d = ifu_exu_shift_d & ~ifu_exu_flush_d &
                   (ifu_exu_shiftop_d != SHOP_RSVD);

  // E register: load from D when not stalled; a kill while stalled still
  // drops the held op so it cannot issue once the stall releases.
  always_ff @(posedge rclk) begin
    if (!rst_l) begin
      valid_e <= 1'b0;
      op_e    <= SHOP_SLL;
      op32_e  <= 1'b0;
    end else if (!ecl_stall_e) begin
      valid_e <= valid_d;
      op_e    <= shift_op_e'(ifu_exu_shiftop_d);
      op32_e  <= ifu_exu_op32_d;
    end else if (ifu_exu_kill_e) begin
      valid_e <= 1'b0;
    end
  end

  // E->W: a stalled E op advances as a bubble; killed ops never reach W.
  always_ff @(posedge rclk) begin
    if (!rst_l) shft_valid_w <= 1'b0;
    else        shft_valid_w <= valid_e & ~ifu_exu_kill_e & ~ecl_stall_e;
  end

  // Direction/enable/fill controls are 0-cycle from the E register.
  assign sra_e = valid_e & (op_e == SHOP_SRA);
  assign sgn_e = op32_e ? byp_alu_rs1_data_e[31] : byp_alu_rs1_data_e[63];

  assign ecl_shft_enshift_e_l     = ~valid_e;
  assign ecl_shft_lshift_e_l      = ~(valid_e & (op_e == SHOP_SLL));
  assign ecl_shft_op32_e          = valid_e & op32_e;
  assign ecl_shft_extendbit_e     = sra_e & sgn_e;
  assign ecl_shft_extend32bit_e_l = ~(sra_e & op32_e & byp_alu_rs1_data_e[31]);

  // Only the two sign positions of rs1 matter here.
  logic unused_rs1;
  assign unused_rs1 = ^{byp_alu_rs1_data_e[62:32], byp_alu_rs1_data_e[30:0]};

  // Count decode runs every cycle, valid or not, to keep the muxes one-hot.
  sparc_exu_ecl_dec2to4 u_dec_shift4 (
    .sel    (byp_alu_rs2_data_e[3:2]),
    .onehot (ecl_shft_shift4_e)
  );

  sparc_exu_ecl_dec2to4 u_dec_shift1 (
    .sel    (byp_alu_rs2_data_e[1:0]),
    .onehot (ecl_shft_shift1_e)
  );

endmodule

// File: tb/tb_sparc_exu_ecl_shftctl.sv
// Self-checking bench for sparc_exu_ecl_shftctl: directed scenarios plus
// randomized traffic against a cycle-level pipeline model.
module tb_sparc_exu_ecl_shftctl;

  logic        rclk = 1'b0;
  logic        rst_l;
  logic        shift_d, op32_d, flush_d, stall, kill;
  logic [1:0]  shiftop_d;
  logic [63:0] rs1;
  logic [3:0]  rs2;
  logic        enshift_l, lshift_l, op32_o, ext, ext32_l, valid_w;
  logic [3:0]  shift4, shift1;

  int n_run  = 0;
  int n_fail = 0;

  // model state: what sits in E and W
  logic       m_ve, m_o32, m_vw;
  logic [1:0] m_op;

  sparc_exu_ecl_shftctl dut (
    .rclk                     (rclk),
    .rst_l                    (rst_l),
    .ifu_exu_shift_d          (shift_d),
    .ifu_exu_shiftop_d        (shiftop_d),
    .ifu_exu_op32_d           (op32_d),
    .ifu_exu_flush_d          (flush_d),
    .ecl_stall_e              (stall),
    .ifu_exu_kill_e           (kill),
    .byp_alu_rs1_data_e       (rs1),
    .byp_alu_rs2_data_e       (rs2),
    .ecl_shft_enshift_e_l     (enshift_l),
    .ecl_shft_lshift_e_l      (lshift_l),
    .ecl_shft_op32_e          (op32_o),
    .ecl_shft_shift4_e        (shift4),
    .ecl_shft_shift1_e        (shift1),
    .ecl_shft_extendbit_e     (ext),
    .ecl_shft_extend32bit_e_l (ext32_l),
    .shft_valid_w             (valid_w)
  );

  always #5 rclk = ~rclk;

  logic [13:0] obs;
  assign obs = {enshift_l, lshift_l, op32_o, shift4, shift1, ext, ext32_l, valid_w};

  // Expected outputs from the model state and current E operands.
  function automatic logic [13:0] model_out();
    logic       sra, sgn;
    logic [3:0] s4, s1;
    s4  = 4'(1 << rs2[3:2]);
    s1  = 4'(1 << rs2[1:0]);
    sra = m_ve && (m_op == 2'd2);
    sgn = m_o32 ? rs1[31] : rs1[63];
    return {~m_ve, ~(m_ve && m_op == 2'd0), m_ve & m_o32, s4, s1,
            sra & sgn, ~(sra & m_o32 & rs1[31]), m_vw};
  endfunction

  // Advance one clock, moving the model along with the DUT.
  task automatic tick();
    logic nvw;
    @(posedge rclk);
    if (!rst_l) begin
      m_ve = 0; m_op = 0; m_o32 = 0; m_vw = 0;
    end else begin
      nvw = m_ve & ~kill & ~stall;
      if (!stall) begin
        m_ve  = shift_d & ~flush_d & (shiftop_d != 2'd3);
        m_op  = shiftop_d;
        m_o32 = op32_d;
      end else if (kill) m_ve = 0;
      m_vw = nvw;
    end
    #1;
  endtask

  task automatic set_d(input logic sh, input logic [1:0] op, input logic o32, input logic fl);
    shift_d = sh; shiftop_d = op; op32_d = o32; flush_d = fl;
  endtask

  // Shifter selects must be one-hot on every cycle, including reset/idle.
  always @(negedge rclk) begin
    n_run++;
    if (!($onehot(shift4) && $onehot(shift1))) begin
      n_fail++;
      $display("FAIL onehot: shift4=%b shift1=%b want one-hot", shift4, shift1);
    end
  end

  task automatic test_reset();
    rst_l = 0; stall = 1; kill = 0; set_d(1, 2'd0, 1, 0);
    rs1 = 64'hFFFF_FFFF_FFFF_FFFF; rs2 = 4'h6;
    tick(); tick();
    @(negedge rclk);
    n_run++;
    if (obs !== {3'b110, 4'b0010, 4'b0100, 3'b010}) begin
      n_fail++; $display("FAIL reset: got %b want %b", obs, {3'b110, 4'b0010, 4'b0100, 3'b010});
    end
  endtask

  task automatic test_sll();
    rst_l = 1; stall = 0; kill = 0; set_d(1, 2'd0, 0, 0);
    tick();
    set_d(0, 2'd0, 0, 0); rs2 = 4'hD; rs1 = {$urandom, $urandom};
    @(negedge rclk);
    n_run++;
    if ({enshift_l, lshift_l, shift4, shift1} !== {2'b00, 4'b1000, 4'b0010}) begin
      n_fail++; $display("FAIL sll_e: got %b want %b", {enshift_l, lshift_l, shift4, shift1}, {2'b00, 4'b1000, 4'b0010});
    end
    tick();
    @(negedge rclk);
    n_run++;
    if (valid_w !== 1'b1) begin n_fail++; $display("FAIL sll_w: got %b want 1", valid_w); end
  endtask

  task automatic test_sra64();
    set_d(1, 2'd2, 0, 0);
    tick();
    set_d(0, 2'd0, 0, 0); rs1 = {1'b1, 31'($urandom), 32'($urandom)}; rs2 = 4'h5;
    @(negedge rclk);
    n_run++;
    if ({ext, ext32_l, shift4, shift1, lshift_l} !== {2'b11, 4'b0010, 4'b0010, 1'b1}) begin
      n_fail++; $display("FAIL sra64: got %b want %b", {ext, ext32_l, shift4, shift1, lshift_l}, {2'b11, 4'b0010, 4'b0010, 1'b1});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    set_d(1, 2'd2, 1, 0);
    tick();
    set_d(1, 2'd1, 1, 0); rs1 = 64'h0000_0000_8000_0000;
    @(negedge rclk);
    n_run++;
    if ({ext, ext32_l, op32_o} !== 3'b101) begin
      n_fail++; $display("FAIL sra32: got %b want 101", {ext, ext32_l, op32_o});
    end
    tick();
    set_d(0, 2'd0, 0, 0);
    @(negedge rclk);
    n_run++;
    if ({ext, ext32_l, enshift_l, lshift_l, valid_w} !== 5'b01011) begin
      n_fail++; $display("FAIL srl32_b2b: got %b want 01011", {ext, ext32_l, enshift_l, lshift_l, valid_w});
    end
    tick();
    @(negedge rclk);
    n_run++;
    if (valid_w !== 1'b1) begin n_fail++; $display("FAIL b2b_w: got %b want 1", valid_w); end
  endtask

  task automatic test_stall_kill();
    logic [1:0] want [4];
    set_d(1, 2'd1, 0, 0);
    tick();
    set_d(0, 2'd0, 0, 0);
    // {enshift_l, valid_w} per cycle: stall, stall+kill, stall, released
    want[0] = 2'b00; want[1] = 2'b00; want[2] = 2'b10; want[3] = 2'b10;
    for (int c = 0; c < 4; c++) begin
      stall = (c < 3); kill = (c == 1);
      @(negedge rclk);
      n_run++;
      if ({enshift_l, valid_w} !== want[c]) begin
        n_fail++; $display("FAIL stall_kill c%0d: got %b want %b", c, {enshift_l, valid_w}, want[c]);
      end
      tick();
    end
    stall = 0; kill = 0;
    @(negedge rclk);
    n_run++;
    if (valid_w !== 1'b0) begin n_fail++; $display("FAIL stall_kill_w: got %b want 0", valid_w); end
  endtask

  task automatic test_rsvd_flush();
    for (int k = 0; k < 2; k++) begin
      if (k == 0) set_d(1, 2'd3, 0, 0); else set_d(1, 2'd0, 0, 1);
      tick();
      set_d(0, 2'd0, 0, 0);
      @(negedge rclk);
      n_run++;
      if ({enshift_l, lshift_l} !== 2'b11) begin
        n_fail++; $display("FAIL rsvd_flush%0d_e: got %b want 11", k, {enshift_l, lshift_l});
      end
      tick();
      @(negedge rclk);
      n_run++;
      if (valid_w !== 1'b0) begin n_fail++; $display("FAIL rsvd_flush%0d_w: got %b want 0", k, valid_w); end
    end
  endtask

  task automatic test_reset_mid_stall();
    set_d(1, 2'd2, 1, 0); rs1 = 64'h0000_0000_8000_0000;
    tick();
    set_d(0, 2'd0, 0, 0); stall = 1;
    @(negedge rclk);
    n_run++;
    if ({enshift_l, op32_o, ext} !== 3'b011) begin
      n_fail++; $display("FAIL pre_reset: got %b want 011", {enshift_l, op32_o, ext});
    end
    rst_l = 0;
    tick();
    @(negedge rclk);
    n_run++;
    if ({enshift_l, lshift_l, op32_o, ext, ext32_l, valid_w} !== 6'b110010) begin
      n_fail++; $display("FAIL reset_mid_stall: got %b want 110010", {enshift_l, lshift_l, op32_o, ext, ext32_l, valid_w});
    end
    rst_l = 1; stall = 0;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_l = ($urandom_range(0, 39) != 0);
      set_d($urandom_range(0, 3) != 0, 2'($urandom), 1'($urandom), $urandom_range(0, 6) == 0);
      stall = ($urandom_range(0, 3) == 0);
      kill  = ($urandom_range(0, 4) == 0);
      rs1   = {$urandom, $urandom};
      rs2   = 4'($urandom);
      @(negedge rclk);
      n_run++;
      if (obs !== model_out()) begin
        n_fail++; $display("FAIL random[%0d]: got %b want %b", i, obs, model_out());
      end
      tick();
    end
  endtask

  initial begin
    m_ve = 0; m_op = 0; m_o32 = 0; m_vw = 0;
    test_reset();
    test_sll();
    test_sra64();
    test_back_to_back();
    test_stall_kill();
    test_rsvd_flush();
    test_reset_mid_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
